// File: rtl/punc_mem_pkg.sv
// Shared types and constants for the PUnC unified-memory arbiter.
// Requester IDs double as the last_gnt / read-tag encoding.
package punc_mem_pkg;

    localparam int PUNC_ADDR_W = 16;
    localparam int PUNC_DATA_W = 16;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_LOAD = 1'b1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_LOAD = 2'd2
    } owner_t;

endpackage

// File: rtl/punc_lock_timer.sv
// Idle counter for a held bus lock; flags expiry on the LOCK_TO-th idle cycle.
// Counts up, clears on clr or expiry, and saturates rather than wrapping.
module punc_lock_timer #(
    parameter int LOCK_TO = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam int TW = $clog2(LOCK_TO + 1);

    logic [TW-1:0] count;

    // Expiry lands on the edge that would complete the LOCK_TO-th idle cycle.
    assign expire = inc && !clr && (count == TW'(LOCK_TO - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr || expire) begin
            count <= '0;
        end else if (inc && (count != TW'(LOCK_TO))) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/punc_mem_arbiter.sv
// Round-robin arbiter between the PUnC core and the loader for the single-port memory,
// with a bus lock for atomic LDI/STI and a lock timeout so the loader is never starved.
//
// state    | meaning
// OWN_NONE | bus free, round-robin between requesters
// OWN_CORE | core holds the lock, only core can be granted
// OWN_LOAD | loader holds the lock, only loader can be granted
module punc_mem_arbiter
    import punc_mem_pkg::*;
#(
    parameter int ADDR_W  = PUNC_ADDR_W,
    parameter int DATA_W  = PUNC_DATA_W,
    parameter int LOCK_TO = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic              core_lock,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,

    input  logic              load_req,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_wdata,
    input  logic              load_lock,
    output logic              load_gnt,
    output logic              load_rvalid,
    output logic [DATA_W-1:0] load_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    owner_t owner, owner_nxt;
    logic   last_gnt;
    logic   rd_pend;
    logic   rd_id;
    logic   timer_inc;
    logic   expire;

    // Grants are gated by rst so every output reads 0 while reset is held.
    always_comb begin
        core_gnt = 1'b0;
        load_gnt = 1'b0;
        if (rst) begin
            case (owner)
                OWN_NONE: begin
                    core_gnt = core_req && (!load_req || (last_gnt == REQ_LOAD));
                    load_gnt = load_req && (!core_req || (last_gnt == REQ_CORE));
                end
                OWN_CORE: core_gnt = core_req;
                OWN_LOAD: load_gnt = load_req;
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_en    = core_gnt || load_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (core_gnt) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (load_gnt) begin
            mem_we    = load_we;
            mem_addr  = load_addr;
            mem_wdata = load_wdata;
        end
    end

    always_comb begin
        owner_nxt = owner;
        if (core_gnt) begin
            owner_nxt = core_lock ? OWN_CORE : OWN_NONE;
        end else if (load_gnt) begin
            owner_nxt = load_lock ? OWN_LOAD : OWN_NONE;
        end else if (expire) begin
            owner_nxt = OWN_NONE;
        end
    end

    assign timer_inc = ((owner == OWN_CORE) && !core_req) ||
                       ((owner == OWN_LOAD) && !load_req);

    punc_lock_timer #(
        .LOCK_TO (LOCK_TO)
    ) u_lock_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (mem_en),
        .inc    (timer_inc),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner    <= OWN_NONE;
            last_gnt <= REQ_LOAD;
            rd_pend  <= 1'b0;
            rd_id    <= REQ_CORE;
        end else begin
            owner   <= owner_nxt;
            rd_pend <= mem_en && !mem_we;
            if (mem_en) begin
                last_gnt <= load_gnt ? REQ_LOAD : REQ_CORE;
                rd_id    <= load_gnt ? REQ_LOAD : REQ_CORE;
            end
        end
    end

    assign core_rvalid = rd_pend && (rd_id == REQ_CORE);
    assign load_rvalid = rd_pend && (rd_id == REQ_LOAD);
    assign core_rdata  = core_rvalid ? mem_rdata : '0;
    assign load_rdata  = load_rvalid ? mem_rdata : '0;

endmodule

// File: doc/punc_mem_arbiter.md
# punc_mem_arbiter

Shares the PUnC single-port unified memory between the processor core (fetch, LD/ST/LDR/STR/LDI/STI traffic) and a program loader/debug requester. It sits between the core's memory control signals and the memory macro. Fair round-robin arbitration with a bus-lock mechanism keeps the two-access indirect instructions (LDI/STI) atomic. A lock timeout guarantees the loader is never starved.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- LOCK_TO, 16, idle cycles after which a held lock is forcibly released (≥2)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- core_req / load_req  in  1  access request, held until granted
- core_we / load_we  in  1  1 = write, 0 = read
- core_addr / load_addr  in  ADDR_W  address
- core_wdata / load_wdata  in  DATA_W  write data
- core_lock / load_lock  in  1  keep ownership after this access
- core_gnt / load_gnt  out  1  access accepted this cycle
- core_rvalid / load_rvalid  out  1  read data valid
- core_rdata / load_rdata  out  DATA_W  read data; 0 when rvalid low
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after a read mem_en

## Operation
- Owner state: OWN_NONE, OWN_CORE, OWN_LOAD.
  - OWN_NONE: arbitration is free.
  - OWN_CORE / OWN_LOAD: only that requester can be granted.
- Grant is combinational from the requests and registered state. At most one gnt is high per cycle. mem_en equals the OR of the gnts. mem_we, mem_addr and mem_wdata are muxed from the granted requester and are 0 when idle.
- Arbitration in OWN_NONE:
  - A single requester is granted.
  - When both request, the requester not in last_gnt wins.
  - last_gnt updates on every grant.
- Lock:
  - A grant with lock=1 moves the state to that requester's owner state.
  - A grant with lock=0 moves the state to OWN_NONE.
  - While locked, the other requester waits even if the owner is idle.
- Lock timer:
  - Clears on every owner grant.
  - Increments each cycle the state is locked and the owner is not requesting.
  - When it reaches LOCK_TO, the state goes to OWN_NONE and the timer clears.
- Read return:
  - A registered read-pending tag records the requester granted for a read.
  - The next cycle, that requester's rvalid=1 and its rdata=mem_rdata.
  - Writes produce no rvalid.
- Reset values: owner=OWN_NONE, last_gnt=load (so core wins the first tie), timer=0, read-pending cleared. All outputs are 0 while rst is low.

## Timing
- Grant latency:
  - 0 cycles when the requester wins in OWN_NONE or is the owner.
  - Otherwise it waits for the other requester's unlocked grant or for the timeout.
- Read data arrives exactly 1 cycle after gnt. Write data is committed at the gnt clock edge.
- Back-to-back accesses are allowed: 1 access per cycle. An rvalid and a new gnt may coincide, for the same or different requesters.
- Requesters must hold req, we, addr, wdata and lock stable until gnt. Deasserting req before gnt is legal and cancels the request.
- Timeout and owner request in the same cycle: the owner request wins and the timer clears.
- Reset asserted mid-operation: any pending rvalid is dropped immediately, and the lock and ownership are lost.
- Timer width is clog2(LOCK_TO+1). The timer saturates at LOCK_TO and never wraps.

## Structure
- Shared package punc_mem_pkg holds:
  - the owner_t enum (OWN_NONE, OWN_CORE, OWN_LOAD)
  - the requester ID constants REQ_CORE=0, REQ_LOAD=1
  - PUNC_ADDR_W and PUNC_DATA_W
- One sub-module, punc_lock_timer, contains the clear/increment/saturate counter and the timeout flag. The grant logic, owner FSM, muxes and read-pending tag stay in the top.

## Test plan
- Core-only read at 0x3000, mem_rdata=0x1234 -> core_gnt the same cycle, mem_addr=0x3000, core_rvalid=1 with core_rdata=0x1234 one cycle later; load outputs stay 0.
- Both requesters read continuously after reset -> grants alternate core, load, core, load; each rvalid is routed to the correct requester.
- Core LDI: read 0x3001 with lock=1, then read 0x4000 with lock=0, with load_req held throughout -> load_gnt stays 0 until the core's lock=0 grant, then asserts on the next cycle.
- Core locks with LOCK_TO=16 and then drops req while the loader requests -> load_gnt asserts after exactly 16 idle cycles.
- Loader write of 0xBEEF to 0x0010 granted, rst pulsed low during the following core read grant -> all outputs 0 immediately, no rvalid after release, first tie after reset goes to core.
